// File: rtl/app_mult_unsigned_seq_pkg.sv
// app_mult_unsigned_seq_pkg: shared FSM states, approximation mask and counter sizing.
package app_mult_unsigned_seq_pkg;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  // Clears product columns [cols-1:0] within a w-bit word (w, cols <= 64).
  function automatic logic [63:0] mask(int cols, int w);
    return ((~64'd0) << cols) & ~((~64'd0) << w);
  endfunction
  function automatic int cnt_width(int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction
endpackage

// File: rtl/app_pp_mask.sv
// app_pp_mask: partial product A<<i with optional low-column truncation.
module app_pp_mask
  import app_mult_unsigned_seq_pkg::*;
#(
  parameter int width1 = 8,
  parameter int width2 = 8,
  parameter int APPROX_COLS = 4
) (
  input  logic [width1-1:0]               a,
  input  logic [cnt_width(width2)-1:0]    i,
  input  logic                            approx_en,
  output logic [width1+width2-1:0]        pp
);
  localparam int W = width1 + width2;
  localparam logic [W-1:0] MASK = W'(mask(APPROX_COLS, W));
  always_comb pp = (W'(a) << i) & (approx_en ? MASK : {W{1'b1}});
endmodule

// File: rtl/app_mult_unsigned_seq.sv
// app_mult_unsigned_seq: iterative shift-add multiplier computing A*B+cin, exact or truncated.
module app_mult_unsigned_seq
  import app_mult_unsigned_seq_pkg::*;
#(
  parameter int width1 = 8,
  parameter int width2 = 8,
  parameter int APPROX_COLS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [width1-1:0]        A,
  input  logic [width2-1:0]        B,
  input  logic                     cin,
  input  logic                     approx_en,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [width1+width2-1:0] sum
);
  localparam int W = width1 + width2;
  localparam int CW = cnt_width(width2);
  logic [1:0] state_q, state_d;
  logic [width1-1:0] a_q, a_d;
  logic [width2-1:0] b_q, b_d;
  logic cin_q, cin_d, approx_q, approx_d, out_valid_q, out_valid_d;
  logic [W-1:0] acc_q, acc_d, sum_q, sum_d, pp, add;
  logic [CW-1:0] cnt_q, cnt_d;
  app_pp_mask #(.width1(width1), .width2(width2), .APPROX_COLS(APPROX_COLS)) u_pp (
    .a(a_q), .i(cnt_q), .approx_en(approx_q), .pp(pp)
  );
  assign in_ready = state_q == IDLE;
  assign out_valid = out_valid_q;
  assign sum = sum_q;
  assign add = b_q[cnt_q] ? pp : '0;
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    cin_d = cin_q;
    approx_d = approx_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    sum_d = sum_q;
    out_valid_d = out_valid_q;
    if (state_q == IDLE && in_valid) begin
      a_d = A;
      b_d = B;
      cin_d = cin;
      approx_d = approx_en;
      acc_d = '0;
      cnt_d = '0;
      state_d = CALC;
    end else if (state_q == CALC) begin
      // Final column folds straight into the result so latency is exactly width2 edges.
      if (cnt_q == CW'(width2 - 1)) begin
        sum_d = acc_q + add + W'(cin_q);
        out_valid_d = 1'b1;
        state_d = DONE;
      end else begin
        acc_d = acc_q + add;
        cnt_d = cnt_q + CW'(1);
      end
    end else if (state_q == DONE && out_ready) begin
      out_valid_d = 1'b0;
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      cin_q <= 1'b0;
      approx_q <= 1'b0;
      acc_q <= '0;
      cnt_q <= '0;
      sum_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      cin_q <= cin_d;
      approx_q <= approx_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      sum_q <= sum_d;
      out_valid_q <= out_valid_d;
    end
  end
endmodule
